// File: rtl/run_sequencer.sv
// Run controller for the 9-bit processor: sequences host start, core reset pulse,
// run and halt/watchdog, owns the data-memory port and counts executed cycles.
module run_sequencer #(
   parameter int          AW     = 8,
   parameter int          DW     = 8,
   parameter logic [15:0] MAXCYC = 16'hFFFF
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Halt,
   output logic          CoreRst,
   output logic          CoreEn,
   input  logic          HostReq,
   input  logic          HostWe,
   input  logic [AW-1:0] HostAddr,
   input  logic [DW-1:0] HostWData,
   output logic          HostGnt,
   input  logic          CoreWe,
   input  logic [AW-1:0] CoreAddr,
   input  logic [DW-1:0] CoreWData,
   output logic          MemWe,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   output logic [15:0]   CycleCt,
   output logic          Done,
   output logic          Timeout
);

   typedef enum logic [1:0] {IDLE, RST, RUN, DONE} stateT;

   stateT       state, nextState;
   logic        startQ;
   logic        startEdge;
   logic        rstCnt;
   logic        timeoutQ;
   logic [15:0] cycleCt;
   logic        atLimit;

   assign startEdge = Start & ~startQ;
   assign atLimit   = (cycleCt == MAXCYC);
   assign CycleCt   = cycleCt;
   assign Timeout   = timeoutQ;

   // State register plus the run bookkeeping; Halt takes priority over the watchdog.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         startQ   <= 1'b0;
         rstCnt   <= 1'b0;
         timeoutQ <= 1'b0;
         cycleCt  <= 16'd0;
      end else begin
         state  <= nextState;
         startQ <= Start;
         case (state)
            IDLE, DONE: begin
               if (startEdge) begin
                  rstCnt   <= 1'b0;
                  cycleCt  <= 16'd0;
                  timeoutQ <= 1'b0;
               end
            end
            RST: rstCnt <= 1'b1;
            RUN: begin
               if (Halt) begin
                  timeoutQ <= 1'b0;
               end else if (atLimit) begin
                  timeoutQ <= 1'b1;
               end else begin
                  cycleCt <= cycleCt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (startEdge) nextState = RST;
         RST:     if (rstCnt) nextState = RUN;
         RUN:     if (Halt || atLimit) nextState = DONE;
         DONE:    if (startEdge) nextState = RST;
         default: nextState = IDLE;
      endcase
   end

   // Core control and port arbitration: the host owns memory only while no run is active.
   always_comb begin
      CoreRst  = 1'b0;
      CoreEn   = 1'b0;
      Done     = 1'b0;
      HostGnt  = 1'b0;
      MemWe    = 1'b0;
      MemAddr  = CoreAddr;
      MemWData = CoreWData;
      case (state)
         IDLE, DONE: begin
            CoreRst  = (state == IDLE);
            Done     = (state == DONE);
            HostGnt  = HostReq;
            MemWe    = HostReq & HostWe;
            MemAddr  = HostAddr;
            MemWData = HostWData;
         end
         RST: CoreRst = 1'b1;
         RUN: begin
            CoreEn = 1'b1;
            MemWe  = CoreWe;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: directed run scenarios with randomized
// memory-port traffic, compared against a run-level reference model.
module tb_run_sequencer;

   localparam int          AW     = 8;
   localparam int          DW     = 8;
   localparam logic [15:0] MAXCYC = 16'd20;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start, Halt;
   logic          CoreRst, CoreEn;
   logic          HostReq, HostWe;
   logic [AW-1:0] HostAddr;
   logic [DW-1:0] HostWData;
   logic          HostGnt;
   logic          CoreWe;
   logic [AW-1:0] CoreAddr;
   logic [DW-1:0] CoreWData;
   logic          MemWe;
   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemWData;
   logic [15:0]   CycleCt;
   logic          Done, Timeout;

   int total = 0;
   int bad   = 0;

   // Model: a run is "active" from the start edge; its first two edges are the
   // core-reset pulse, after which it executes until halt or the watchdog.
   bit mActive, mDone, mTo, mStartQ;
   int mAge, mCount;

   run_sequencer #(.AW(AW), .DW(DW), .MAXCYC(MAXCYC)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
      .CoreRst(CoreRst), .CoreEn(CoreEn),
      .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWData(HostWData),
      .HostGnt(HostGnt),
      .CoreWe(CoreWe), .CoreAddr(CoreAddr), .CoreWData(CoreWData),
      .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .CycleCt(CycleCt), .Done(Done), .Timeout(Timeout)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mActive = 0; mDone = 0; mTo = 0; mStartQ = 0; mAge = 0; mCount = 0;
   endtask

   task automatic modelEdge();
      bit startEdge;
      startEdge = Start && !mStartQ;
      mStartQ   = Start;
      if (mActive && mAge >= 3) begin
         if (Halt) begin
            mActive = 0; mDone = 1; mTo = 0;
         end else if (mCount == int'(MAXCYC)) begin
            mActive = 0; mDone = 1; mTo = 1;
         end else begin
            mCount++;
         end
      end else if (mActive) begin
         mAge++;
      end else if (startEdge) begin
         mActive = 1; mAge = 1; mCount = 0; mTo = 0; mDone = 0;
      end
   endtask

   task automatic checkOutput();
      bit inRun, inRst;
      inRun = mActive && mAge >= 3;
      inRst = mActive && mAge < 3;
      chk("CoreRst", CoreRst, (!mActive && !mDone) || inRst);
      chk("CoreEn", CoreEn, inRun);
      chk("Done", Done, mDone && !mActive);
      chk("Timeout", Timeout, mTo);
      chk("CycleCt", CycleCt, mCount);
      chk("HostGnt", HostGnt, !mActive && HostReq);
      chk("MemWe", MemWe, inRun ? CoreWe : (!mActive ? (HostReq & HostWe) : 1'b0));
      chk("MemAddr", MemAddr, mActive ? CoreAddr : HostAddr);
      if (!inRst) chk("MemWData", MemWData, inRun ? CoreWData : HostWData);
   endtask

   task automatic applyStimulus();
      HostReq   = 1'($urandom);
      HostWe    = 1'($urandom);
      HostAddr  = AW'($urandom);
      HostWData = DW'($urandom);
      CoreWe    = 1'($urandom);
      CoreAddr  = AW'($urandom);
      CoreWData = DW'($urandom);
   endtask

   task automatic tick(input bit rnd);
      if (rnd) applyStimulus();
      @(posedge Clk);
      if (!Reset) modelReset();
      else modelEdge();
      #1;
      checkOutput();
   endtask

   initial begin
      logic [AW-1:0] addr;
      int            n;
      int            h;

      Reset = 1'b1; Start = 1'b0; Halt = 1'b0;
      HostReq = 1'b0; HostWe = 1'b0; HostAddr = '0; HostWData = '0;
      CoreWe = 1'b0; CoreAddr = '0; CoreWData = '0;
      modelReset();

      // Asynchronous reset mid-cycle with a host write pending.
      #3;
      Reset = 1'b0; HostReq = 1'b1; HostWe = 1'b1; HostAddr = 8'h10; HostWData = 8'h5A;
      #1;
      checkOutput();
      chk("rstMemAddr", MemAddr, 8'h10);
      chk("rstMemWe", MemWe, 1);
      chk("rstHostGnt", HostGnt, 1);
      tick(0);
      Reset = 1'b1;
      tick(1);
      tick(1);

      // Start pulse, halt in the fifth run cycle.
      Start = 1'b1; tick(1);
      chk("rstPulse1", CoreRst, 1);
      Start = 1'b0; tick(1);
      chk("rstPulse2", CoreRst, 1);
      tick(1);
      chk("runEntry", CoreRst, 0);
      repeat (4) tick(1);
      Halt = 1'b1; tick(1); Halt = 1'b0;
      chk("haltCount", CycleCt, 4);
      chk("haltDone", Done, 1);
      chk("haltTimeout", Timeout, 0);
      HostReq = 1'b0; CoreWe = 1'b1;
      #1;
      chk("doneMemWe", MemWe, 0);
      tick(1);

      // Watchdog run with host contention during RUN.
      Start = 1'b1; tick(1);
      Start = 1'b0; tick(1); tick(1);
      HostReq = 1'b1; HostWe = 1'b1; CoreWe = 1'b1; CoreAddr = 8'h22;
      #1;
      chk("runHostGnt", HostGnt, 0);
      chk("runMemAddr", MemAddr, 8'h22);
      chk("runMemWe", MemWe, 1);
      n = 0;
      while (!Done && n < 60) begin
         tick(1);
         n++;
      end
      chk("watchdogReached", n < 60, 1);
      chk("watchdogTimeout", Timeout, 1);
      chk("watchdogCount", CycleCt, 20);
      addr = AW'($urandom);
      HostReq = 1'b1; HostAddr = addr;
      #1;
      chk("doneHostGnt", HostGnt, 1);
      chk("doneMemAddr", MemAddr, addr);

      // Start held high across the run: a single run, no retrigger from DONE.
      Start = 1'b1; tick(1);
      chk("rerunDone", Done, 0);
      chk("rerunCount", CycleCt, 0);
      chk("rerunTimeout", Timeout, 0);
      tick(1); tick(1);
      repeat (2) tick(1);
      Halt = 1'b1; tick(1); Halt = 1'b0;
      repeat (5) tick(1);
      chk("heldStartDone", Done, 1);
      chk("heldStartCount", CycleCt, 2);
      Start = 1'b0; tick(1);
      Start = 1'b1; tick(1);
      chk("restartCount", CycleCt, 0);
      chk("restartCoreRst", CoreRst, 1);
      Start = 1'b0; tick(1); tick(1);

      // Reset in the middle of a run, then Start held through reset release.
      repeat (7) tick(1);
      chk("preAbortCount", CycleCt, 7);
      #3;
      Reset = 1'b0;
      #1;
      modelReset();
      checkOutput();
      chk("abortCount", CycleCt, 0);
      chk("abortDone", Done, 0);
      tick(1);
      Start = 1'b1; Reset = 1'b1;
      tick(1);
      chk("releaseStartRst", CoreRst, 1);
      tick(1); tick(1);
      repeat (3) tick(1);
      Halt = 1'b1; tick(1); Halt = 1'b0;
      repeat (3) tick(1);
      chk("releaseSingleRun", Done, 1);
      Start = 1'b0; tick(1);

      // Random-length runs, the first halting in its first run cycle.
      for (int r = 0; r < 4; r++) begin
         h = (r == 0) ? 0 : int'($urandom_range(1, 12));
         Start = 1'b1; tick(1);
         Start = 1'b0; tick(1); tick(1);
         repeat (h) tick(1);
         Halt = 1'b1; tick(1); Halt = 1'b0;
         chk("randHaltCount", CycleCt, h);
         chk("randHaltDone", Done, 1);
         repeat (2) tick(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
